// File: rtl/div113_pkg.sv
// Shared constants and types for the divide-by-113 datapath.
// Latency: none. This file only holds declarations.
// Backpressure: none. This file only holds declarations.
package div113_pkg;

  localparam int DIVISOR = 113;
  localparam int DIV_W   = 48;
  localparam int DIGIT_W = 3;
  localparam int REM_W   = 7;
  localparam int STEPS   = DIV_W / DIGIT_W;
  localparam int STEP_W  = 4;
  localparam int LUT_W   = REM_W + DIGIT_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [REM_W-1:0]   rem_t;
  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/div48_by113_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
// Latency: none. It only groups wires.
// Backpressure: valid/ready on both the operand side and the result side.
interface div48_by113_seq_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [div113_pkg::DIV_W-1:0] in_dividend;
  logic                        out_valid;
  logic                        out_ready;
  logic [div113_pkg::DIV_W-1:0] out_quot;
  logic [div113_pkg::REM_W-1:0] out_rem;

  // divider side
  modport slave (
    input  in_valid, in_dividend, out_ready,
    output in_ready, out_valid, out_quot, out_rem
  );

  // producer/consumer side
  modport master (
    output in_valid, in_dividend, out_ready,
    input  in_ready, out_valid, out_quot, out_rem
  );

endinterface

// File: rtl/div48_by113_seq_quot_res.sv
// Radix-8 digit table: {rem, digit} -> {quotient digit, next remainder} for divisor 113.
// Latency: purely combinational.
// Backpressure: none.
module quot_res
  import div113_pkg::*;
(
  input  logic [LUT_W-1:0] x,
  output logic [LUT_W-1:0] z
);

  digit_t q;
  rem_t   r;

  // Pick the largest multiple of 113 not exceeding x, then take the leftover.
  // Legal inputs never exceed 903, so a 3-bit digit always suffices.
  always_comb begin
    q = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= LUT_W'(k * DIVISOR)) q = digit_t'(k);
    end
    r = rem_t'(x - ({{REM_W{1'b0}}, q} * LUT_W'(DIVISOR)));
    z = {q, r};
  end

endmodule

// File: rtl/div48_by113_seq.sv
// Sequential 48-bit / 113 divider, one radix-8 digit per clock via an external quot_res table.
// Latency: accept edge, then 16 RUN edges; out_valid is seen by the consumer 17 edges after accept.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module div48_by113_seq
  import div113_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  div48_by113_seq_if.slave bus,
  output logic [LUT_W-1:0] lut_x,
  input  logic [LUT_W-1:0] lut_z
);

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] step;
  logic [DIV_W-1:0]  dvd;
  logic [DIV_W-1:0]  quot;
  rem_t              rem_reg;
  digit_t            digit;
  logic              accept;

  assign digit  = dvd[DIV_W-1 -: DIGIT_W];
  assign accept = (state == IDLE) && bus.in_valid;

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last digit, DONE -> IDLE on hand-off.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (step == STEP_W'(STEPS - 1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one digit per RUN cycle; everything is frozen in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd     <= '0;
      quot    <= '0;
      rem_reg <= '0;
      step    <= '0;
    end else if (accept) begin
      dvd     <= bus.in_dividend;
      quot    <= '0;
      rem_reg <= '0;
      step    <= '0;
    end else if (state == RUN) begin
      dvd     <= {dvd[DIV_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
      quot    <= {quot[DIV_W-DIGIT_W-1:0], lut_z[LUT_W-1 -: DIGIT_W]};
      rem_reg <= lut_z[REM_W-1:0];
      step    <= step + STEP_W'(1);
    end
  end

  // The table input is forced to zero outside RUN so it never sees stale operands.
  assign lut_x = (state == RUN) ? {rem_reg, digit} : '0;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_quot  = quot;
  assign bus.out_rem   = rem_reg;

  // The remainder is always below 113, so {rem, digit} can never exceed 112*8+7.
  a_lut_in_range: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> ({rem_reg, digit} <= LUT_W'(903)));

  // The table must return a legal remainder; there is no recovery path if it does not.
  a_lut_rem_legal: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (lut_z[REM_W-1:0] <= rem_t'(DIVISOR - 1)));

endmodule

// File: tb/tb_div48_by113_seq.sv
// Self-checking bench for div48_by113_seq with the quot_res table attached.
// Latency: checks the 17-edge accept-to-result timing.
// Backpressure: exercises held results, ignored in_valid and mid-run reset.
module tb_div48_by113_seq;
  import div113_pkg::*;

  typedef struct {
    logic [47:0] dividend;
    logic [47:0] quot;
    logic [6:0]  rem;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] lut_x;
  logic [9:0] lut_z;

  int checks  = 0;
  int errors  = 0;
  int lut_bad = 0;

  always #5 clk = ~clk;

  div48_by113_seq_if bus ();

  div48_by113_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .lut_x (lut_x),
    .lut_z (lut_z)
  );

  quot_res u_tab (
    .x (lut_x),
    .z (lut_z)
  );

  // Any table remainder above 112 is a fault, wherever it happens.
  always @(negedge clk) begin
    if (!rst && (lut_z[6:0] > 7'd112)) lut_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer a dividend, wait for the result, then hand it off after 'gap' idle cycles.
  // lat is the number of edges from the accept edge to the edge where the consumer sees out_valid.
  task automatic run_div(input logic [47:0] d, input int gap, input bit noise,
                         output logic [47:0] q, output logic [6:0] r, output int lat);
    int n;
    logic [63:0] junk;
    q   = '0;
    r   = '0;
    lat = -1;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dividend = d;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid    = 1'b0;
    junk            = {$urandom, $urandom};
    bus.in_dividend = junk[47:0];
    n = 1;
    while (!bus.out_valid && n < 100) begin
      bus.out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    if (!bus.out_valid) begin
      check("result_timeout", 64'(bus.out_valid), 64'd1);
      return;
    end
    lat = n;
    q   = bus.out_quot;
    r   = bus.out_rem;
    repeat (gap) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [47:0] q;
    logic [6:0]  r;
    int          lat;
    int          n;
    logic [63:0] t;
    logic [47:0] d;
    longint unsigned du;

    vecs[0] = '{48'd0,               48'd0,             7'd0};
    vecs[1] = '{48'd113,             48'd1,             7'd0};
    vecs[2] = '{48'd112,             48'd0,             7'd112};
    vecs[3] = '{48'd1000,            48'd8,             7'd96};
    vecs[4] = '{48'd281474976710655, 48'd2490928997439, 7'd48};
    vecs[5] = '{48'd226,             48'd2,             7'd0};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.out_ready   = 1'b0;
    #1;
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_quot",  64'(bus.out_quot),  64'd0);
    check("reset_out_rem",   64'(bus.out_rem),   64'd0);
    check("reset_lut_x",     64'(lut_x),         64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].dividend, 0, 1'b0, q, r, lat);
      check($sformatf("vec%0d_quot", i), 64'(q), 64'(vecs[i].quot));
      check($sformatf("vec%0d_rem", i),  64'(r), 64'(vecs[i].rem));
      if (i == 0) check("latency_edges", 64'(lat), 64'd17);
    end

    // Held result under back-pressure: 5000 / 113 = 44 rem 28.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 48'd5000;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_lut_x_idle", 64'(lut_x), 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = (i % 2) == 0;
      bus.in_dividend = 48'd7;
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            64'({bus.out_valid, bus.in_ready, bus.out_quot, bus.out_rem}),
            64'({1'b1, 1'b0, 48'd44, 7'd28}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a run, at step 7.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 48'd123456789;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    check("abort_out_quot",  64'(bus.out_quot),  64'd0);
    check("abort_lut_x",     64'(lut_x),         64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div(48'd226, 1, 1'b0, q, r, lat);
    check("after_abort_quot", 64'(q), 64'd2);
    check("after_abort_rem",  64'(r), 64'd0);

    // Random dividends against plain integer division, with random gaps and out_ready noise.
    for (int i = 0; i < 2000; i++) begin
      t = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       d = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 300));
        1:       d = 48'(64'(t[40:0]) * 64'd113);
        default: d = t[47:0];
      endcase
      du = 64'(d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_div(d, $urandom_range(0, 3), 1'b1, q, r, lat);
      check("rand_quot", 64'(q), du / 64'd113);
      check("rand_rem",  64'(r), du % 64'd113);
    end

    check("lut_rem_range", 64'(lut_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
